pixel_req_array: RTL and testbench

//  Requester side of the pixel-level req/gnt arbitration protocol for the EBC sensor array.

---
 rtl/lib_arbiter_pkg.sv | 29 ++
 rtl/pixel_req_cell.sv | 79 +++++++
 rtl/pixel_req_array.sv | 80 ++++++++
 tb/tb_pixel_req_array.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lib_arbiter_pkg.sv
// Shared types and helpers for the pixel req/gnt arbitration hierarchy.
// Used by pixel_req_cell and pixel_req_array.
package lib_arbiter_pkg;

   // Request polarity carried on the 2-bit set lines toward the group arbiters
   typedef enum logic [1:0] {
      POL_NONE = 2'b00,
      POL_ON   = 2'b01,
      POL_OFF  = 2'b10
   } pol_t;

   // Per-pixel requester state
   typedef enum logic [1:0] {
      PIX_IDLE = 2'b00,
      PIX_REQ  = 2'b01,
      PIX_REFR = 2'b10
   } pix_state_t;

   // Width of a counter able to hold the refractory length; never narrower than 1 bit
   function automatic int refr_w(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

   // Only the ON and OFF codes are real events; 00 and 11 mean nothing happened
   function automatic logic is_valid_event(input logic [1:0] ev);
      return (ev == POL_ON) || (ev == POL_OFF);
   endfunction

endpackage

// File: rtl/pixel_req_cell.sv
// Single-pixel requester: IDLE -> REQ -> REFR -> IDLE state machine with a
// refractory down-counter. The drop flag (event seen while busy) only exists
// when PIXEL_REQ_OVF_CNT_EN is defined, since nothing else consumes it.
module pixel_req_cell
   import lib_arbiter_pkg::*;
#(
   parameter int REFRACTORY_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] pix_event,
   input  logic       gnt,
   output logic [1:0] set_pol,
   output logic       req
`ifdef PIXEL_REQ_OVF_CNT_EN
   ,
   output logic       drop
`endif
);

   localparam int REFR_W = refr_w(REFRACTORY_CYCLES);

   pix_state_t        state;
   pol_t              pol;
   logic [REFR_W-1:0] cnt;
   logic              ev_valid;

   assign ev_valid = is_valid_event(pix_event);

   // Requester FSM: latch polarity once, hold it until granted, then sit out the refractory period
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= PIX_IDLE;
         pol   <= POL_NONE;
         cnt   <= '0;
      end else begin
         case (state)
            PIX_IDLE: begin
               if (ev_valid) begin
                  state <= PIX_REQ;
                  pol   <= pol_t'(pix_event);
               end
            end
            PIX_REQ: begin
               if (gnt) begin
                  pol <= POL_NONE;
                  if (REFRACTORY_CYCLES == 0) begin
                     state <= PIX_IDLE;
                  end else begin
                     state <= PIX_REFR;
                     cnt   <= REFR_W'(REFRACTORY_CYCLES);
                  end
               end
            end
            PIX_REFR: begin
               if (cnt <= REFR_W'(1)) begin
                  state <= PIX_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - REFR_W'(1);
               end
            end
            default: begin
               state <= PIX_IDLE;
               pol   <= POL_NONE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign set_pol = pol;
   assign req     = (state == PIX_REQ);

`ifdef PIXEL_REQ_OVF_CNT_EN
   assign drop = ev_valid && (state != PIX_IDLE);
`endif

endmodule

// File: rtl/pixel_req_array.sv
// PIXELS x PIXELS array of pixel requesters feeding the group arbiter tree.
// Build option PIXEL_REQ_OVF_CNT_EN adds a saturating count of dropped events;
// without it ovf_cnt_o is tied to zero.
module pixel_req_array
   import lib_arbiter_pkg::*;
#(
   parameter int PIXELS            = 16,
   parameter int REFRACTORY_CYCLES = 4,
   parameter int OVF_W             = 16
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic [PIXELS-1:0][PIXELS-1:0][1:0] event_i,
   input  logic [PIXELS-1:0][PIXELS-1:0]      gnt_i,
   output logic [PIXELS-1:0][PIXELS-1:0][1:0] set_o,
   output logic                               active_o,
   output logic [OVF_W-1:0]                   ovf_cnt_o
);

   logic [PIXELS-1:0][PIXELS-1:0] req_flags;
`ifdef PIXEL_REQ_OVF_CNT_EN
   logic [PIXELS-1:0][PIXELS-1:0] drop_flags;
`endif

   for (genvar r = 0; r < PIXELS; r++) begin : g_row
      for (genvar c = 0; c < PIXELS; c++) begin : g_col
         pixel_req_cell #(
            .REFRACTORY_CYCLES(REFRACTORY_CYCLES)
         ) u_cell (
            .clk      (clk_i),
            .reset    (reset_i),
            .pix_event(event_i[r][c]),
            .gnt      (gnt_i[r][c]),
            .set_pol  (set_o[r][c]),
            .req      (req_flags[r][c])
`ifdef PIXEL_REQ_OVF_CNT_EN
            ,
            .drop     (drop_flags[r][c])
`endif
         );
      end
   end

   assign active_o = |req_flags;

`ifdef PIXEL_REQ_OVF_CNT_EN
   localparam int POP_W = $clog2(PIXELS * PIXELS + 1);
   localparam int SUM_W = ((OVF_W > POP_W) ? OVF_W : POP_W) + 1;
   localparam logic [OVF_W-1:0] OVF_MAX = '1;

   logic [POP_W-1:0] drop_count;
   logic [SUM_W-1:0] ovf_sum;

   // Population count of pixels dropping a valid event this cycle
   always_comb begin
      drop_count = '0;
      for (int r = 0; r < PIXELS; r++) begin
         for (int c = 0; c < PIXELS; c++) begin
            drop_count = drop_count + POP_W'(drop_flags[r][c]);
         end
      end
   end

   assign ovf_sum = SUM_W'(ovf_cnt_o) + SUM_W'(drop_count);

   // Saturating accumulator; the extra sum bit lets a large burst clamp instead of wrapping
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ovf_cnt_o <= '0;
      end else if (ovf_sum > SUM_W'(OVF_MAX)) begin
         ovf_cnt_o <= OVF_MAX;
      end else begin
         ovf_cnt_o <= ovf_sum[OVF_W-1:0];
      end
   end
`else
   assign ovf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pixel_req_array.sv
// Self-checking bench for pixel_req_array (PIXELS=16, REFRACTORY_CYCLES=4, OVF_W=4).
// Expected overflow counts follow PIXEL_REQ_OVF_CNT_EN when it is defined.
module tb_pixel_req_array;

   localparam int PIXELS = 16;
   localparam int REFR   = 4;
   localparam int OVF_W  = 4;
   localparam int SET_W  = PIXELS * PIXELS * 2;
   localparam int OVF_LIM = (1 << OVF_W) - 1;

`ifdef PIXEL_REQ_OVF_CNT_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   typedef logic [PIXELS-1:0][PIXELS-1:0][1:0] ev_arr_t;
   typedef logic [PIXELS-1:0][PIXELS-1:0]      gnt_arr_t;

   typedef struct {
      logic [SET_W-1:0] set;
      logic             act;
      int               ovf;
   } exp_t;

   typedef struct {
      logic [1:0] ev;
      logic       g;
      logic [1:0] exp_set;
      logic       exp_act;
      int         drops;
   } vec_t;

   logic       clk_i = 1'b0;
   logic       reset_i;
   ev_arr_t    event_i;
   gnt_arr_t   gnt_i;
   ev_arr_t    set_o;
   logic       active_o;
   logic [OVF_W-1:0] ovf_cnt_o;

   int   checks   = 0;
   int   failures = 0;
   int   exp_ovf  = 0;
   exp_t sb[$];
   vec_t tbl[17];

   pixel_req_array #(
      .PIXELS(PIXELS),
      .REFRACTORY_CYCLES(REFR),
      .OVF_W(OVF_W)
   ) dut (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .event_i  (event_i),
      .gnt_i    (gnt_i),
      .set_o    (set_o),
      .active_o (active_o),
      .ovf_cnt_o(ovf_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Guard against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [SET_W-1:0] actual,
                              input logic [SET_W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [SET_W-1:0] onePix(input int r, input int c, input logic [1:0] v);
      ev_arr_t tmp;
      tmp = '0;
      tmp[r][c] = v;
      return tmp;
   endfunction

   task automatic addDrops(input int n);
      if (OVF_EN)
         exp_ovf = (exp_ovf + n > OVF_LIM) ? OVF_LIM : exp_ovf + n;
      else
         exp_ovf = 0;
   endtask

   // Drive one cycle of inputs, queue the expectation, then compare after the edge
   task automatic applyStimulus(input ev_arr_t ev, input gnt_arr_t g, input exp_t e);
      exp_t got;
      event_i = ev;
      gnt_i   = g;
      sb.push_back(e);
      @(posedge clk_i);
      #1;
      event_i = '0;
      gnt_i   = '0;
      got = sb.pop_front();
      checkOutput("set_o", set_o, got.set);
      checkOutput("active_o", SET_W'(active_o), SET_W'(got.act));
      checkOutput("ovf_cnt_o", SET_W'(ovf_cnt_o), SET_W'(got.ovf));
   endtask

   task automatic doReset();
      reset_i = 1'b1;
      event_i = '0;
      gnt_i   = '0;
      @(posedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
      exp_ovf = 0;
      sb.delete();
   endtask

   initial begin
      ev_arr_t  ev;
      gnt_arr_t g;
      exp_t     e;

      // Pixel [2][7] sequence: request, drop, grant, refractory, collision, invalid/stray inputs
      tbl[0]  = '{2'b01, 1'b0, 2'b01, 1'b1, 0};
      tbl[1]  = '{2'b00, 1'b0, 2'b01, 1'b1, 0};
      tbl[2]  = '{2'b10, 1'b0, 2'b01, 1'b1, 1};
      tbl[3]  = '{2'b00, 1'b1, 2'b00, 1'b0, 0};
      tbl[4]  = '{2'b10, 1'b0, 2'b00, 1'b0, 1};
      tbl[5]  = '{2'b01, 1'b0, 2'b00, 1'b0, 1};
      tbl[6]  = '{2'b10, 1'b0, 2'b00, 1'b0, 1};
      tbl[7]  = '{2'b10, 1'b0, 2'b00, 1'b0, 1};
      tbl[8]  = '{2'b10, 1'b0, 2'b10, 1'b1, 0};
      tbl[9]  = '{2'b10, 1'b1, 2'b00, 1'b0, 1};
      tbl[10] = '{2'b00, 1'b0, 2'b00, 1'b0, 0};
      tbl[11] = '{2'b11, 1'b1, 2'b00, 1'b0, 0};
      tbl[12] = '{2'b00, 1'b0, 2'b00, 1'b0, 0};
      tbl[13] = '{2'b00, 1'b0, 2'b00, 1'b0, 0};
      tbl[14] = '{2'b11, 1'b0, 2'b00, 1'b0, 0};
      tbl[15] = '{2'b00, 1'b1, 2'b00, 1'b0, 0};
      tbl[16] = '{2'b01, 1'b0, 2'b01, 1'b1, 0};

      // Reset state
      reset_i = 1'b1;
      event_i = '0;
      gnt_i   = '0;
      @(negedge clk_i);
      #2;
      checkOutput("reset set_o", set_o, '0);
      checkOutput("reset active_o", SET_W'(active_o), '0);
      checkOutput("reset ovf_cnt_o", SET_W'(ovf_cnt_o), '0);
      @(negedge clk_i);
      reset_i = 1'b0;

      // Table-driven sequence on pixel [2][7]
      for (int i = 0; i < 17; i++) begin
         ev = '0;
         g  = '0;
         ev[2][7] = tbl[i].ev;
         g[2][7]  = tbl[i].g;
         addDrops(tbl[i].drops);
         e.set = onePix(2, 7, tbl[i].exp_set);
         e.act = tbl[i].exp_act;
         e.ovf = exp_ovf;
         applyStimulus(ev, g, e);
      end

      // Single event held for 20 cycles without a grant
      doReset();
      ev = '0;
      ev[0][0] = 2'b01;
      e.set = onePix(0, 0, 2'b01);
      e.act = 1'b1;
      e.ovf = 0;
      applyStimulus(ev, '0, e);
      for (int i = 0; i < 20; i++) applyStimulus('0, '0, e);

      // Asynchronous reset while a request is outstanding
      doReset();
      ev = '0;
      ev[3][5] = 2'b10;
      e.set = onePix(3, 5, 2'b10);
      e.act = 1'b1;
      e.ovf = 0;
      applyStimulus(ev, '0, e);
      @(negedge clk_i);
      reset_i = 1'b1;
      #1;
      checkOutput("async reset set_o", set_o, '0);
      checkOutput("async reset active_o", SET_W'(active_o), '0);
      @(negedge clk_i);
      reset_i = 1'b0;
      exp_ovf = 0;
      e.set = '0;
      e.act = 1'b0;
      applyStimulus('0, '0, e);
      ev = '0;
      ev[3][5] = 2'b01;
      e.set = onePix(3, 5, 2'b01);
      e.act = 1'b1;
      applyStimulus(ev, '0, e);

      // Overflow: 16 pixels in REQ, then 5+5+16+14 dropped events
      doReset();
      ev = '0;
      for (int c = 0; c < PIXELS; c++) ev[1][c] = 2'b01;
      e.set = ev;
      e.act = 1'b1;
      e.ovf = 0;
      applyStimulus(ev, '0, e);
      begin
         int burst[4] = '{5, 5, 16, 14};
         for (int b = 0; b < 4; b++) begin
            ev = '0;
            for (int c = 0; c < burst[b]; c++) ev[1][c] = 2'b10;
            addDrops(burst[b]);
            e.ovf = exp_ovf;
            applyStimulus(ev, '0, e);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
